fir_lpf_mac: RTL
================

// Module: fir_lpf_mac
// PURPOSE
//  Parametrised successor of the fixed 16-tap nibble-serial low-pass FIR in the final-project datapath.
//  - Collects DW-bit signed samples over DW/IN_W input beats, using a valid/ready handshake.
//  - Runs a single time-shared multiply-accumulate over TAPS runtime-writable coefficients.
//  - Emits one rounded DW-bit result per input sample.
//  - Sits between the sample source and the result checker / downstream filter stage.
// PARAMETERS
//  TAPS      16      number of taps (>=2); coefficient RAM depth and MAC cycle count
//  DW        8       sample and result width, signed two's complement
//  IN_W      4       input beat width; DW % IN_W == 0; BEATS = DW/IN_W
//  CW        16      coefficient width, signed Q(CW-FRAC).FRAC
//  FRAC      12      coefficient fraction bits; result = acc >>> FRAC, rounded
//  COEF_INIT 16-tap LPF  packed TAPS*CW reset coefficients, h[0] in LSBs:
//                    FFF8 FFF0 0020 0060 FF40 FEC0 0280 0800 0800 0280 FEC0 FF40 0060 0020 FFF0 FFF8
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-low reset
//  x_valid    in   1          x_beat carries a valid input beat
//  x_beat     in   IN_W       input sample beat, least-significant beat first
//  x_ready    out  1          block accepts a beat this cycle
//  coef_we    in   1          coefficient write strobe
//  coef_addr  in   clog2(TAPS) coefficient index k
//  coef_data  in   CW         coefficient value h[k]
//  busy       out  1          high in MAC and OUT states
//  y_valid    out  1          one-cycle pulse; y holds a valid result
//  y          out  DW         filtered sample, signed
// BEHAVIOUR
//  Reset (reset==0 at clk edge), including mid-operation:
//  - state<=IDLE; beat count, accumulator and delay line x[0..TAPS-1] <= 0; h[] <= COEF_INIT.
//  - y_valid=0, y=0, busy=0, x_ready=1 on the following cycle.
//  States: IDLE -> GATHER -> MAC -> OUT -> IDLE.
//  - IDLE: x_ready=1.
//    - Accepted beat (x_valid&x_ready) goes into the assembly register bits[IN_W-1:0].
//    - Next state is GATHER, or, when BEATS==1, the sample is committed directly.
//  - GATHER: x_ready=1.
//    - Beat i fills bits[(i+1)*IN_W-1 : i*IN_W].
//    - Idle cycles (x_valid=0) hold the state and the beat count; there is no timeout.
//    - On beat BEATS-1 the sample is committed: x[k]<=x[k-1] for k>0, x[0]<=assembled sample.
//    - Then acc<=0, k<=0, next state MAC.
//  - MAC: x_ready=0, busy=1; exactly TAPS cycles.
//    - Each cycle: acc <= acc + sext(x[k])*sext(h[k]); k++.
//    - After k==TAPS-1, next state OUT.
//  - OUT: one cycle.
//    - y_valid=1; y registered and held until the next OUT; busy=1; x_ready=0.
//    - Next state IDLE.
//  Latency: last accepted beat at cycle t -> y_valid at cycle t+TAPS+1.
//  Throughput: one sample per BEATS+TAPS+1 cycles at most.
//  Arithmetic:
//  - ACC_W = DW+CW+clog2(TAPS); no accumulator overflow is possible.
//  - Rounding is half-up: r = acc[ACC_W-1:FRAC] + acc[FRAC-1]; y = r[DW-1:0] (wrap).
//  Coefficient port:
//  - Write is committed when coef_we=1 and busy=0.
//  - Write is dropped silently when busy=1 (the MAC never sees a half-updated set).
//  - Write in the same cycle as a sample commit lands before the MAC starts.
//  - coef_addr >= TAPS is ignored.
// CONFIGURATION
//  FIR_LPF_SATURATE_EN
//  - Defined: r is clamped to [-2^(DW-1), 2^(DW-1)-1] before truncation, rounding carry included.
//  - Undefined: plain wrap to DW bits; no extra logic.
// STRUCTURE
//  - Package fir_lpf_pkg: state enum (IDLE/GATHER/MAC/OUT), a clog2 function, ACC_W derivation
//    and the default LPF coefficient constant.
//  - One sub-module, fir_lpf_coef_ram: TAPS x CW register file with a sync write port, an async
//    read port, reset-to-COEF_INIT and the write-block input driven by busy.
// TESTING (defaults unless noted)
//  - Reset mid-MAC: pull reset low during MAC cycle 5 -> next cycle y_valid=0, busy=0, x_ready=1;
//    delay line reads back zero.
//  - Impulse: beats 0x0,0x1 (sample 0x10), then zero samples -> 7th result y=0x03, 8th y=0x08,
//    5th y=0xFF; y_valid spacing = 19 cycles at full rate.
//  - DC step: 16+ samples of 0x7F -> steady y=0x8D (wrap). With FIR_LPF_SATURATE_EN -> y=0x7F.
//  - Coefficient rewrite: write h[0]=0x1000, all other h=0; input 0x5A -> y=0x5A.
//    A write while busy=1 leaves h unchanged.
//  - Handshake: x_valid gaps of 3 cycles between beats -> same y as gap-free input;
//    x_ready low for exactly TAPS+1 cycles per sample.
//  - Parameter sweep TAPS=8, DW=12, IN_W=4 (BEATS=3) -> results match the bench reference model.

Source files
------------

// File: rtl/fir_lpf_pkg.sv
// Shared types and constants for the time-shared low-pass FIR.
// State encoding, width helpers and the default 16-tap coefficient set.
package fir_lpf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    MAC,
    OUT
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Headroom of clog2(taps) bits keeps the sum of products exact.
  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

  // Packed with h[0] in the least-significant 16 bits.
  localparam logic [255:0] LPF_COEF = {
    16'hFFF8, 16'hFFF0, 16'h0020, 16'h0060,
    16'hFF40, 16'hFEC0, 16'h0280, 16'h0800,
    16'h0800, 16'h0280, 16'hFEC0, 16'hFF40,
    16'h0060, 16'h0020, 16'hFFF0, 16'hFFF8
  };

endpackage

// File: rtl/fir_lpf_if.sv
// Sample-in / result-out bundle of the FIR.
// master = sample source and result sink, slave = filter.
interface fir_lpf_if #(
  parameter int DW   = 8,
  parameter int IN_W = 4
);
  logic            x_valid;
  logic [IN_W-1:0] x_beat;
  logic            x_ready;
  logic            y_valid;
  logic [DW-1:0]   y;

  modport master (
    output x_valid,
    output x_beat,
    input  x_ready,
    input  y_valid,
    input  y
  );

  modport slave (
    input  x_valid,
    input  x_beat,
    output x_ready,
    output y_valid,
    output y
  );
endinterface

// File: rtl/fir_lpf_coef_ram.sv
// Coefficient register file: sync write, async read, reset to the LPF set.
// Writes are blocked while the MAC walks the taps.
module fir_lpf_coef_ram
  import fir_lpf_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int CW   = 16,
  parameter int AW   = clog2(TAPS),
  parameter logic [TAPS*CW-1:0] COEF_INIT = (TAPS*CW)'(LPF_COEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          blk,
  input  logic [AW-1:0] addr,
  input  logic [CW-1:0] data,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] h_q [TAPS];

  // Addresses beyond TAPS-1 match no entry and fall away.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++)
        h_q[i] <= COEF_INIT[i*CW +: CW];
    end else if (we && !blk) begin
      for (int i = 0; i < TAPS; i++)
        if (addr == AW'(i))
          h_q[i] <= data;
    end
  end

  assign rdata = h_q[raddr];

endmodule

// File: rtl/fir_lpf_mac.sv
// Beat-serial-in, single-MAC low-pass FIR with writable taps.
// FIR_LPF_SATURATE_EN clamps the rounded result instead of wrapping.
module fir_lpf_mac
  import fir_lpf_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int DW   = 8,
  parameter int IN_W = 4,
  parameter int CW   = 16,
  parameter int FRAC = 12,
  parameter logic [TAPS*CW-1:0] COEF_INIT = (TAPS*CW)'(LPF_COEF)
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_lpf_if.slave               io,
  input  logic                   coef_we,
  input  logic [clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]          coef_data,
  output logic                   busy
);

  localparam int BEATS = DW / IN_W;
  localparam int AW    = clog2(TAPS);
  localparam int BW    = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int ACC_W = acc_w(DW, CW, TAPS);

  state_t                   state_q;
  logic [BW-1:0]            beat_q;
  logic [DW-1:0]            asm_q;
  logic [DW-1:0]            samp;
  logic signed [DW-1:0]     xd_q [TAPS];
  logic [AW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_nx;
  logic signed [CW-1:0]     h_k;
  logic signed [DW+CW-1:0]  prod;
  logic [DW-1:0]            y_nx;
  logic                     take;
  logic                     last;

  fir_lpf_coef_ram #(
    .TAPS      (TAPS),
    .CW        (CW),
    .AW        (AW),
    .COEF_INIT (COEF_INIT)
  ) u_coef (
    .clk   (clk),
    .reset (reset),
    .we    (coef_we),
    .blk   (busy),
    .addr  (coef_addr),
    .data  (coef_data),
    .raddr (k_q),
    .rdata (h_k)
  );

  assign take = io.x_valid && io.x_ready;
  assign last = (beat_q == BW'(BEATS - 1));

  always_comb begin
    samp = asm_q;
    for (int i = 0; i < BEATS; i++)
      if (beat_q == BW'(i))
        samp[i*IN_W +: IN_W] = io.x_beat;
  end

  assign prod   = xd_q[k_q] * h_k;
  assign acc_nx = acc_q + {{AW{prod[DW+CW-1]}}, prod};

`ifdef FIR_LPF_SATURATE_EN
  localparam int RW = ACC_W - FRAC;
  localparam logic signed [RW:0] SMAX = (RW+1)'((1 << (DW-1)) - 1);
  localparam logic signed [RW:0] SMIN = (RW+1)'(-(1 << (DW-1)));

  logic signed [RW:0] r;

  // One guard bit so the rounding carry cannot hide an overflow.
  assign r = $signed({acc_nx[ACC_W-1], acc_nx[ACC_W-1:FRAC]})
           + $signed({{RW{1'b0}}, acc_nx[FRAC-1]});

  always_comb begin
    y_nx = r[DW-1:0];
    if (r > SMAX)
      y_nx = SMAX[DW-1:0];
    else if (r < SMIN)
      y_nx = SMIN[DW-1:0];
  end
`else
  assign y_nx = acc_nx[FRAC +: DW]
              + {{(DW-1){1'b0}}, acc_nx[FRAC-1]};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      asm_q      <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      for (int i = 0; i < TAPS; i++)
        xd_q[i] <= '0;
      io.y_valid <= 1'b0;
      io.y       <= '0;
      io.x_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      io.y_valid <= 1'b0;
      unique case (state_q)
        IDLE, GATHER: begin
          if (take) begin
            asm_q <= samp;
            if (last) begin
              xd_q[0] <= samp;
              for (int i = 1; i < TAPS; i++)
                xd_q[i] <= xd_q[i-1];
              beat_q     <= '0;
              acc_q      <= '0;
              k_q        <= '0;
              io.x_ready <= 1'b0;
              busy       <= 1'b1;
              state_q    <= MAC;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= GATHER;
            end
          end
        end
        MAC: begin
          acc_q <= acc_nx;
          k_q   <= k_q + 1'b1;
          if (k_q == AW'(TAPS - 1)) begin
            io.y       <= y_nx;
            io.y_valid <= 1'b1;
            state_q    <= OUT;
          end
        end
        OUT: begin
          io.x_ready <= 1'b1;
          busy       <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
